// File: rtl/rd_b_fc_scaled.sv
// rd_b_fc_scaled: reads one tile of OCH_T packed 8-bit scaled activations from
// the scaled-data BRAM (4 per 32-bit word) and presents them as one flat vector.
// Build option: define RD_B_FC_SCALED_OREG_EN to add an output register stage
// on o_icht_scaled / o_valid / o_ot_done / o_n_ready (latency +1 cycle).
module rd_b_fc_scaled #(
    parameter int OCH    = 120,
    parameter int OCH_B  = 8,
    parameter int I_F_BW = 8,
    localparam int OCH_T           = OCH / OCH_B,
    localparam int B_SCALED_DATA_D = (OCH + 3) / 4,
    localparam int B_SCALED_ADDR_W = $clog2(B_SCALED_DATA_D),
    localparam int IDX_BW          = $clog2(OCH),
    localparam int OUT_W           = OCH_T * I_F_BW
) (
    input  logic                       clk,
    input  logic                       areset,
    input  logic                       i_run,
    input  logic [IDX_BW-1:0]          i_scaled_idx,
    output logic [OUT_W-1:0]           o_icht_scaled,
    output logic                       o_valid,
    output logic                       o_idle,
    output logic                       o_run,
    output logic                       o_n_ready,
    output logic                       o_en_err,
    output logic                       o_ot_done,
    output logic [B_SCALED_ADDR_W-1:0] b_o_scaled_addr,
    output logic                       b_o_scaled_ce,
    output logic [3:0]                 b_o_scaled_byte_we,
    input  logic [31:0]                b_i_scaled_q
);

    // Worst case word span of a tile (offset 3) sizes the assembly buffer.
    localparam int BUF_WORDS = (OCH_T + 6) / 4;
    localparam int BUF_W     = BUF_WORDS * 32;
    localparam int CNT_W     = $clog2(BUF_WORDS + 1);
    // One extra bit so base+n past the end of the BRAM does not wrap.
    localparam int WADDR_W   = IDX_BW + 1;

    typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_OUT} state_t;

    state_t                     state_q;
    logic [IDX_BW-1:0]          idx_q;
    logic [CNT_W-1:0]           words_q;
    logic [CNT_W-1:0]           rd_cnt_q;
    logic [CNT_W-1:0]           cap_cnt_q;
    logic [B_SCALED_ADDR_W-1:0] addr_q;
    logic                       ce_q;
    logic                       slot_q;
    logic                       cap_pend_q;
    logic                       cap_ce_q;
    logic [BUF_W-1:0]           buf_q;
    logic [BUF_W-1:0]           buf_d;
    logic [OUT_W-1:0]           data_q;
    logic                       valid_q;
    logic                       nready_q;
    logic                       err_q;
    logic                       idle;
    logic                       start;
    logic [WADDR_W-1:0]         first_waddr;
    logic [WADDR_W-1:0]         next_waddr;
    logic [CNT_W-1:0]           words_run;

    // Align the buffer by the start offset and blank activations past OCH.
    function automatic logic [OUT_W-1:0] assemble(input logic [BUF_W-1:0]  b,
                                                  input logic [IDX_BW-1:0] idx);
        logic [BUF_W-1:0] sh;
        logic [OUT_W-1:0] r;
        sh = b >> {idx[1:0], 3'b000};
        r  = sh[OUT_W-1:0];
        for (int j = 0; j < OCH_T; j++) begin
            if (int'(idx) + j >= OCH) r[j*I_F_BW +: I_F_BW] = '0;
        end
        return r;
    endfunction

    assign start       = i_run && idle;
    assign first_waddr = WADDR_W'(i_scaled_idx >> 2);
    assign next_waddr  = WADDR_W'(idx_q >> 2) + WADDR_W'(rd_cnt_q);
    assign words_run   = CNT_W'((int'(i_scaled_idx[1:0]) + OCH_T + 3) / 4);

    // Merge the word returned this cycle (zero for unissued slots) into the buffer.
    always_comb begin
        buf_d = buf_q;
        for (int w = 0; w < BUF_WORDS; w++) begin
            if (cap_pend_q && cap_cnt_q == CNT_W'(w))
                buf_d[w*32 +: 32] = cap_ce_q ? b_i_scaled_q : 32'h0;
        end
    end

    // Request FSM: issue word reads, collect returned data, emit the tile.
    always_ff @(posedge clk) begin
        if (areset) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            words_q    <= '0;
            rd_cnt_q   <= '0;
            cap_cnt_q  <= '0;
            addr_q     <= '0;
            ce_q       <= 1'b0;
            slot_q     <= 1'b0;
            cap_pend_q <= 1'b0;
            cap_ce_q   <= 1'b0;
            buf_q      <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            nready_q   <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            valid_q    <= 1'b0;
            nready_q   <= 1'b0;
            cap_pend_q <= slot_q;
            cap_ce_q   <= ce_q;
            buf_q      <= buf_d;
            if (cap_pend_q) cap_cnt_q <= cap_cnt_q + CNT_W'(1);
            if (i_run && !idle) err_q <= 1'b1;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        idx_q     <= i_scaled_idx;
                        words_q   <= words_run;
                        rd_cnt_q  <= CNT_W'(1);
                        cap_cnt_q <= '0;
                        slot_q    <= 1'b1;
                        ce_q      <= (first_waddr < WADDR_W'(B_SCALED_DATA_D));
                        if (first_waddr < WADDR_W'(B_SCALED_DATA_D))
                            addr_q <= first_waddr[B_SCALED_ADDR_W-1:0];
                        state_q   <= S_READ;
                    end
                end
                S_READ: begin
                    if (rd_cnt_q == words_q) begin
                        slot_q   <= 1'b0;
                        ce_q     <= 1'b0;
                        nready_q <= 1'b1;
                        state_q  <= S_DRAIN;
                    end else begin
                        rd_cnt_q <= rd_cnt_q + CNT_W'(1);
                        ce_q     <= (next_waddr < WADDR_W'(B_SCALED_DATA_D));
                        if (next_waddr < WADDR_W'(B_SCALED_DATA_D))
                            addr_q <= next_waddr[B_SCALED_ADDR_W-1:0];
                    end
                end
                S_DRAIN: begin
                    data_q  <= assemble(buf_d, idx_q);
                    valid_q <= 1'b1;
                    state_q <= S_OUT;
                end
                S_OUT: begin
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef RD_B_FC_SCALED_OREG_EN
    logic [OUT_W-1:0] data2_q;
    logic             valid2_q;
    logic             nready2_q;

    // Retiming stage: delay result, valid/done and n_ready by one cycle.
    always_ff @(posedge clk) begin
        if (areset) begin
            data2_q   <= '0;
            valid2_q  <= 1'b0;
            nready2_q <= 1'b0;
        end else begin
            valid2_q  <= valid_q;
            nready2_q <= nready_q;
            if (valid_q) data2_q <= data_q;
        end
    end

    // The request stays busy until the delayed done pulse has been seen.
    assign idle          = (state_q == S_IDLE) && !valid2_q;
    assign o_icht_scaled = data2_q;
    assign o_valid       = valid2_q;
    assign o_ot_done     = valid2_q;
    assign o_n_ready     = nready2_q;
`else
    assign idle          = (state_q == S_IDLE);
    assign o_icht_scaled = data_q;
    assign o_valid       = valid_q;
    assign o_ot_done     = valid_q;
    assign o_n_ready     = nready_q;
`endif

    assign o_idle             = idle;
    assign o_run              = !idle;
    assign o_en_err           = err_q;
    assign b_o_scaled_addr    = addr_q;
    assign b_o_scaled_ce      = ce_q;
    assign b_o_scaled_byte_we = 4'b0000;

endmodule

// File: tb/tb_rd_b_fc_scaled.sv
// Testbench for rd_b_fc_scaled: BRAM model plus a byte-level reference model.
module tb_rd_b_fc_scaled;
    localparam int OCH   = 120;
    localparam int OCH_T = 15;
    localparam int DEPTH = 30;
    localparam int OUT_W = 120;
`ifdef RD_B_FC_SCALED_OREG_EN
    localparam int EXTRA = 1;
`else
    localparam int EXTRA = 0;
`endif

    logic              clk = 1'b0;
    logic              areset = 1'b1;
    logic              i_run = 1'b0;
    logic [6:0]        i_scaled_idx = '0;
    logic [OUT_W-1:0]  o_icht_scaled;
    logic              o_valid, o_idle, o_run, o_n_ready, o_en_err, o_ot_done;
    logic [4:0]        b_o_scaled_addr;
    logic              b_o_scaled_ce;
    logic [3:0]        b_o_scaled_byte_we;
    logic [31:0]       b_i_scaled_q;

    logic [7:0] act [OCH];
    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    bit err_exp  = 1'b0;

    rd_b_fc_scaled dut (
        .clk                (clk),
        .areset             (areset),
        .i_run              (i_run),
        .i_scaled_idx       (i_scaled_idx),
        .o_icht_scaled      (o_icht_scaled),
        .o_valid            (o_valid),
        .o_idle             (o_idle),
        .o_run              (o_run),
        .o_n_ready          (o_n_ready),
        .o_en_err           (o_en_err),
        .o_ot_done          (o_ot_done),
        .b_o_scaled_addr    (b_o_scaled_addr),
        .b_o_scaled_ce      (b_o_scaled_ce),
        .b_o_scaled_byte_we (b_o_scaled_byte_we),
        .b_i_scaled_q       (b_i_scaled_q)
    );

    always #5 clk = ~clk;

    // BRAM model: 1-cycle read latency, junk on the bus when not enabled.
    always @(posedge clk) begin
        if (b_o_scaled_ce && b_o_scaled_addr < 5'(DEPTH))
            b_i_scaled_q <= {act[{b_o_scaled_addr, 2'd3}], act[{b_o_scaled_addr, 2'd2}],
                             act[{b_o_scaled_addr, 2'd1}], act[{b_o_scaled_addr, 2'd0}]};
        else
            b_i_scaled_q <= $urandom;
    end

    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Tile expected from the activation table: byte j is activation idx+j, 0 past OCH.
    function automatic logic [OUT_W-1:0] model(input int idx);
        logic [OUT_W-1:0] r;
        r = '0;
        for (int j = 0; j < OCH_T; j++)
            r[j*8 +: 8] = (idx + j < OCH) ? act[idx + j] : 8'h00;
        return r;
    endfunction

    // One request with cycle-by-cycle checks; rerun_k > 0 pulses i_run again in that cycle.
    task automatic do_req(input int idx, input int rerun_k, input string tag);
        int w, lat, base;
        logic [OUT_W-1:0] exp_d;
        bit exp_ce;
        w     = ((idx % 4) + OCH_T + 3) / 4;
        lat   = w + 2 + EXTRA;
        base  = idx / 4;
        exp_d = model(idx);
        @(negedge clk);
        check($sformatf("%s/idle_before", tag), 160'(o_idle), 160'(1'b1));
        i_run        = 1'b1;
        i_scaled_idx = 7'(idx);
        for (int k = 1; k <= lat + 3; k++) begin
            @(negedge clk);
            i_run = (k == rerun_k);
            if (rerun_k > 0 && k == rerun_k + 1) err_exp = 1'b1;
            exp_ce = (k <= w) && (base + k - 1 < DEPTH);
            check($sformatf("%s/valid@%0d", tag, k), 160'(o_valid), 160'(k == lat));
            check($sformatf("%s/done@%0d", tag, k), 160'(o_ot_done), 160'(k == lat));
            check($sformatf("%s/nready@%0d", tag, k), 160'(o_n_ready), 160'(k == lat - 1));
            check($sformatf("%s/idle@%0d", tag, k), 160'(o_idle), 160'(k > lat));
            check($sformatf("%s/run@%0d", tag, k), 160'(o_run), 160'(k <= lat));
            check($sformatf("%s/err@%0d", tag, k), 160'(o_en_err), 160'(err_exp));
            check($sformatf("%s/ce@%0d", tag, k), 160'(b_o_scaled_ce), 160'(exp_ce));
            if (exp_ce)
                check($sformatf("%s/addr@%0d", tag, k), 160'(b_o_scaled_addr), 160'(base + k - 1));
            if (k >= lat)
                check($sformatf("%s/data@%0d", tag, k), 160'(o_icht_scaled), 160'(exp_d));
        end
        check($sformatf("%s/byte_we", tag), 160'(b_o_scaled_byte_we), 160'(4'b0000));
    endtask

    initial begin
        for (int n = 0; n < OCH; n++) act[n] = 8'(n + 1);

        // Reset state
        repeat (2) @(negedge clk);
        check("rst/idle", 160'(o_idle), 160'(1'b1));
        check("rst/run", 160'(o_run), 160'(1'b0));
        check("rst/valid", 160'(o_valid), 160'(1'b0));
        check("rst/done", 160'(o_ot_done), 160'(1'b0));
        check("rst/nready", 160'(o_n_ready), 160'(1'b0));
        check("rst/err", 160'(o_en_err), 160'(1'b0));
        check("rst/ce", 160'(b_o_scaled_ce), 160'(1'b0));
        check("rst/addr", 160'(b_o_scaled_addr), 160'(5'd0));
        check("rst/data", 160'(o_icht_scaled), 160'(0));
        areset = 1'b0;

        // Aligned, unaligned and end-of-memory tiles
        do_req(0, 0, "idx0");
        check("idx0/known", 160'(o_icht_scaled), 160'(120'h0f0e0d0c0b0a09080706050403020_1));
        do_req(15, 0, "idx15");
        do_req(110, 0, "idx110");
        check("idx110/known", 160'(o_icht_scaled), 160'(120'h0000000000787776757473727170_6f));

        // Busy request during read, and at the done pulse
        do_req(0, 3, "busy_read");
        do_req(8, 6 + EXTRA, "busy_done");

        // Reset in the middle of a read aborts it
        @(negedge clk);
        i_run        = 1'b1;
        i_scaled_idx = 7'd0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            i_run = 1'b0;
            check($sformatf("abort/ce@%0d", k), 160'(b_o_scaled_ce), 160'(1'b1));
            check($sformatf("abort/addr@%0d", k), 160'(b_o_scaled_addr), 160'(k - 1));
        end
        areset  = 1'b1;
        err_exp = 1'b0;
        @(negedge clk);
        areset = 1'b0;
        check("abort/idle", 160'(o_idle), 160'(1'b1));
        check("abort/ce", 160'(b_o_scaled_ce), 160'(1'b0));
        check("abort/addr", 160'(b_o_scaled_addr), 160'(5'd0));
        check("abort/err", 160'(o_en_err), 160'(1'b0));
        check("abort/data", 160'(o_icht_scaled), 160'(0));
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            check($sformatf("abort/novalid@%0d", k), 160'(o_valid), 160'(1'b0));
            check($sformatf("abort/stillidle@%0d", k), 160'(o_idle), 160'(1'b1));
        end
        do_req(105, 0, "idx105");

        // Random memory contents and random tile starts
        for (int n = 0; n < OCH; n++) act[n] = 8'($urandom);
        for (int t = 0; t < 24; t++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            do_req(int'($urandom_range(0, OCH - 1)), 0, $sformatf("rnd%0d", t));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
